// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code up/down counter: mode encodings and
// binary/Gray conversion helpers (evaluated at full 32-bit width, callers truncate).
package gray_pkg;

   typedef enum logic {
      MODE_WRAP = 1'b0,
      MODE_SAT  = 1'b1
   } mode_e;

   function automatic logic [31:0] bin_to_gray(input logic [31:0] bin);
      return bin ^ (bin >> 1);
   endfunction

   // Zero-extended inputs convert correctly because the unused top bits XOR as zero.
   function automatic logic [31:0] gray_to_bin(input logic [31:0] gray);
      logic [31:0] bin;
      logic        acc;
      acc = 1'b0;
      for (int i = 31; i >= 0; i--) begin
         acc    = acc ^ gray[i];
         bin[i] = acc;
      end
      return bin;
   endfunction

endpackage

// File: rtl/gray2bin.sv
// Purely combinational Gray-to-binary converter: each binary bit is the XOR of
// all Gray bits at or above its position.
module gray2bin #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] gray,
   output logic [WIDTH-1:0] bin
);

   logic acc;

   // NOTE: every variable written here gets a value before any branch or loop,
   // so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      acc = 1'b0;
      bin = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         acc    = acc ^ gray[i];
         bin[i] = acc;
      end
   end

endmodule

// File: rtl/gray_updown_counter.sv
// Up/down counter with registered binary and Gray outputs, wrap or saturate
// behaviour at the ends, and a one-cycle pulse on wrap-around.
module gray_updown_counter
   import gray_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int SATURATE  = 0,
   parameter int RESET_BIN = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             up_dn,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_gray,
   output logic [WIDTH-1:0] gray_out,
   output logic [WIDTH-1:0] binary_out,
   output logic             at_max,
   output logic             at_min,
   output logic             wrap_pulse
);

   localparam mode_e            MODE       = (SATURATE != 0) ? MODE_SAT : MODE_WRAP;
   localparam logic [WIDTH-1:0] RESET_VAL  = WIDTH'(RESET_BIN);
   localparam logic [WIDTH-1:0] RESET_GRAY = WIDTH'(bin_to_gray(32'(RESET_BIN)));
   localparam logic [WIDTH-1:0] ALL_ONES   = '1;

   logic [WIDTH-1:0] bin_q, bin_d;
   logic [WIDTH-1:0] gray_q, gray_d;
   logic             wrap_q, wrap_d;
   logic [WIDTH-1:0] load_bin;

   gray2bin #(.WIDTH(WIDTH)) u_gray2bin (
      .gray (load_gray),
      .bin  (load_bin)
   );

   always_comb begin
      bin_d  = bin_q;
      wrap_d = 1'b0;
      if (clear) begin
         bin_d = '0;
      end else if (load) begin
         bin_d = load_bin;
      end else if (enable) begin
         if (up_dn) begin
            if (bin_q != ALL_ONES) begin
               bin_d = bin_q + 1'b1;
            end else if (MODE == MODE_WRAP) begin
               bin_d  = '0;
               wrap_d = 1'b1;
            end
         end else begin
            if (bin_q != '0) begin
               bin_d = bin_q - 1'b1;
            end else if (MODE == MODE_WRAP) begin
               bin_d  = ALL_ONES;
               wrap_d = 1'b1;
            end
         end
      end
      // Gray is derived from the next count so both registers update together.
      gray_d = WIDTH'(bin_to_gray(32'(bin_d)));
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bin_q  <= RESET_VAL;
         gray_q <= RESET_GRAY;
         wrap_q <= 1'b0;
      end else begin
         bin_q  <= bin_d;
         gray_q <= gray_d;
         wrap_q <= wrap_d;
      end
   end

   assign binary_out = bin_q;
   assign gray_out   = gray_q;
   assign wrap_pulse = wrap_q;
   assign at_max     = (bin_q == ALL_ONES);
   assign at_min     = (bin_q == '0);

endmodule

// File: doc/gray_updown_counter.md
GRAY_UPDOWN_COUNTER -- requirements
Module: gray_updown_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4: counter width in bits; legal range 2..32.
REQ-002 SHALL have parameter SATURATE, default 0: 0 = wrap mode, 1 = saturate mode.
REQ-003 SHALL have parameter RESET_BIN, default 0: binary count value loaded on reset; must be less than 2^WIDTH.
REQ-004 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port enable  input  1  when high, count one step in the direction given by up_dn.
REQ-007 SHALL have port up_dn  input  1  count direction: 1 = increment, 0 = decrement.
REQ-008 SHALL have port clear  input  1  synchronous clear to binary 0.
REQ-009 SHALL have port load  input  1  synchronous load from load_gray.
REQ-010 SHALL have port load_gray  input  WIDTH  Gray-coded value to load.
REQ-011 SHALL have port gray_out  output  WIDTH  registered Gray code of the current count.
REQ-012 SHALL have port binary_out  output  WIDTH  registered binary count.
REQ-013 SHALL have port at_max  output  1  high while binary_out equals all ones.
REQ-014 SHALL have port at_min  output  1  high while binary_out equals zero.
REQ-015 SHALL have port wrap_pulse  output  1  one-cycle pulse on a wrap-around.

Function
REQ-016 SHALL apply this priority on each rising edge: clear, then load, then enable, otherwise hold.
REQ-017 SHALL on clear set binary_out to 0 and gray_out to 0, regardless of load and enable.
REQ-018 SHALL on load (with clear low) set binary_out to the Gray-to-binary conversion of load_gray, and gray_out to load_gray, ignoring enable.
REQ-019 SHALL on enable with up_dn=1 set binary_out to binary_out+1, modulo 2^WIDTH.
REQ-020 SHALL on enable with up_dn=0 set binary_out to binary_out-1, modulo 2^WIDTH.
REQ-021 SHALL keep gray_out equal to binary_out XOR (binary_out >> 1) in the same cycle, with 1-clock latency from the control inputs and no extra lag cycle.
REQ-022 SHALL change exactly one gray_out bit per enabled step in wrap mode, including on wrap-around.
REQ-023 SHALL in wrap mode step all-ones to 0 when counting up, and 0 to all-ones when counting down.
REQ-024 SHALL in wrap mode assert wrap_pulse for exactly the one cycle following either wrap step.
REQ-025 SHALL in saturate mode hold the count at all-ones when counting up, and at 0 when counting down.
REQ-026 SHALL in saturate mode keep wrap_pulse at 0 permanently.
REQ-027 SHALL keep wrap_pulse at 0 after clear, load, or hold cycles, even when the count value jumps.
REQ-028 SHALL decode at_max and at_min from the count register only, without depending on any input.
REQ-029 SHALL treat a direction change on consecutive enabled cycles as a normal step, with no dead cycle.

Reset
REQ-030 SHALL on rst_n low immediately set binary_out to RESET_BIN, gray_out to Gray(RESET_BIN), and wrap_pulse to 0.
REQ-031 SHALL derive at_max and at_min during reset from RESET_BIN.
REQ-032 SHALL abandon any in-progress operation on a reset assertion mid-operation, with no residual pulse.
REQ-033 SHALL resume counting on the first rising edge after rst_n deasserts.

Structure
REQ-034 SHALL place the mode encodings (MODE_WRAP=0, MODE_SAT=1) and the bin-to-gray and gray-to-bin conversion functions in shared package gray_pkg.
REQ-035 SHALL implement the Gray-to-binary prefix-XOR conversion as sub-module gray2bin, parametrised by WIDTH and purely combinational.
REQ-036 SHALL keep all state in one register set: binary count, gray_out, and wrap_pulse.

Verification
REQ-037 SHALL cover up-count wrap: WIDTH=4, SATURATE=0, up_dn=1, enable held for 16 cycles from 0 -> gray sequence 0,1,3,2,6,...,8 then 0, with wrap_pulse high for 1 cycle after 15->0.
REQ-038 SHALL cover down-count wrap: from 0 with up_dn=0 and enable=1 -> binary_out=15, gray_out=4'b1000, wrap_pulse=1 for 1 cycle, and at_max=1.
REQ-039 SHALL cover saturation: SATURATE=1, count up from 14 for 3 cycles -> 15,15,15, at_max=1, wrap_pulse never asserted.
REQ-040 SHALL cover priority: load_gray=4'b1101 with load=1 and enable=1 -> binary_out=9, gray_out=4'b1101; then clear and load together -> binary_out=0.
REQ-041 SHALL cover mid-count reset: RESET_BIN=5, rst_n pulsed low between clock edges at count 11 -> binary_out=5 and gray_out=4'b0111 without waiting for a clock edge, and counting resumes at 6.
REQ-042 SHALL cover single-bit change: random enable/up_dn for 10k cycles in wrap mode -> Hamming distance between consecutive gray_out values is at most 1.
